// File: rtl/debounced_logic_unit.sv
// Per-channel switch synchroniser + debouncer feeding a mode-selectable logic function for LD1.
// Optional F_EDGE_CNT_EN macro adds an 8-bit rising-edge counter on led_f (rise_cnt).
module debounced_logic_unit #(
    parameter int unsigned N_IN      = 4,
    parameter int unsigned DB_CYCLES = 1000000
) (
    input  logic            sys_clk,
    input  logic            sys_rst,
    input  logic [N_IN-1:0] sw,
    input  logic [2:0]      mode,
    output logic [N_IN-1:0] sw_db,
    output logic            led_f,
    output logic            f_chg,
    output logic [7:0]      rise_cnt
);

    localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int unsigned PC_W  = (N_IN > 1) ? $clog2(N_IN + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [PC_W-1:0]  MAJ_HALF = PC_W'(N_IN / 2);

    typedef enum logic {
        ST_STABLE   = 1'b0,
        ST_CHANGING = 1'b1
    } db_state_t;

    logic [N_IN-1:0] s1;
    logic [N_IN-1:0] s2;
    logic            led_f_q;
    logic            f;
    logic [PC_W-1:0] pop;

    // Two-flop synchroniser for the raw switch pins
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= sw;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < int'(N_IN); i++) begin : g_ch
        db_state_t      state;
        logic [CNT_W-1:0] cnt;
        logic           db_q;

        // A change is accepted only after DB_CYCLES consecutive differing samples
        always_ff @(posedge sys_clk) begin
            if (sys_rst) begin
                state <= ST_STABLE;
                cnt   <= '0;
                db_q  <= 1'b0;
            end else begin
                case (state)
                    ST_STABLE: begin
                        if (s2[i] != db_q) begin
                            if (DB_CYCLES == 1) begin
                                db_q <= s2[i];
                                cnt  <= '0;
                            end else begin
                                cnt   <= CNT_W'(1);
                                state <= ST_CHANGING;
                            end
                        end else begin
                            cnt <= '0;
                        end
                    end
                    ST_CHANGING: begin
                        if (s2[i] == db_q) begin
                            cnt   <= '0;
                            state <= ST_STABLE;
                        end else if (cnt == CNT_LAST) begin
                            db_q  <= s2[i];
                            cnt   <= '0;
                            state <= ST_STABLE;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        cnt   <= '0;
                        state <= ST_STABLE;
                    end
                endcase
            end
        end

        assign sw_db[i] = db_q;
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < int'(N_IN); i++) begin
            pop = pop + PC_W'(sw_db[i]);
        end
    end

    // Logic function select; MAJ is strict majority so ties resolve to 0
    always_comb begin
        f = 1'b0;
        case (mode)
            3'd0:    f = &sw_db;
            3'd1:    f = |sw_db;
            3'd2:    f = ^sw_db;
            3'd3:    f = ~(&sw_db);
            3'd4:    f = ~(|sw_db);
            3'd5:    f = ~(^sw_db);
            3'd6:    f = (pop > MAJ_HALF);
            default: f = sw_db[0];
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            led_f   <= 1'b0;
            led_f_q <= 1'b0;
            f_chg   <= 1'b0;
        end else begin
            led_f   <= f;
            led_f_q <= led_f;
            f_chg   <= (led_f != led_f_q);
        end
    end

`ifdef F_EDGE_CNT_EN
    // f_chg with led_f high marks a rising edge of led_f; wraps naturally at 8 bits
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            rise_cnt <= 8'd0;
        end else if (f_chg && led_f) begin
            rise_cnt <= rise_cnt + 8'd1;
        end
    end
`else
    assign rise_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_debounced_logic_unit.sv
// Randomised + directed bench for debounced_logic_unit against a cycle-level behavioural model.
module tb_debounced_logic_unit;

    localparam int unsigned N_IN = 4;
    localparam int unsigned DB   = 4;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic [3:0] sw;
    logic [2:0] mode;
    logic [3:0] sw_db;
    logic       led_f;
    logic       f_chg;
    logic [7:0] rise_cnt;

    debounced_logic_unit #(.N_IN(N_IN), .DB_CYCLES(DB)) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sw       (sw),
        .mode     (mode),
        .sw_db    (sw_db),
        .led_f    (led_f),
        .f_chg    (f_chg),
        .rise_cnt (rise_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    // Model state
    logic [3:0] m_d1, m_d2, m_db;
    int         m_run [4];
    logic       m_led, m_led_q, m_chg;
    logic [7:0] m_rc;

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_func(input logic [3:0] v, input logic [2:0] m);
        int ones;
        ones = $countones(v);
        case (m)
            3'd0:    return v == 4'hF;
            3'd1:    return v != 4'h0;
            3'd2:    return (ones % 2) == 1;
            3'd3:    return v != 4'hF;
            3'd4:    return v == 4'h0;
            3'd5:    return (ones % 2) == 0;
            3'd6:    return ones > 2;
            default: return v[0];
        endcase
    endfunction

    // Advance the model by one rising edge using pre-edge values
    task automatic model_step();
        if (sys_rst) begin
            m_d1 = '0; m_d2 = '0; m_db = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_led = 0; m_led_q = 0; m_chg = 0; m_rc = '0;
        end else begin
`ifdef F_EDGE_CNT_EN
            if (m_chg && m_led) m_rc = m_rc + 8'd1;
`endif
            m_chg   = (m_led != m_led_q);
            m_led_q = m_led;
            m_led   = ref_func(m_db, mode);
            for (int i = 0; i < 4; i++) begin
                if (m_d2[i] != m_db[i]) begin
                    m_run[i]++;
                    if (m_run[i] >= int'(DB)) begin
                        m_db[i]  = m_d2[i];
                        m_run[i] = 0;
                    end
                end else begin
                    m_run[i] = 0;
                end
            end
            m_d2 = m_d1;
            m_d1 = sw;
        end
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        check("sw_db", 32'(sw_db), 32'(m_db));
        check("led_f", 32'(led_f), 32'(m_led));
        check("f_chg", 32'(f_chg), 32'(m_chg));
        check("rise_cnt", 32'(rise_cnt), 32'(m_rc));
    endtask

    initial begin
        logic [7:0] exp_tab;
        logic [7:0] rc0;
        int         hold;

        sys_rst = 1'b1; sw = 4'h0; mode = 3'd0;
        repeat (3) step();
        check("rst_db", 32'(sw_db), 32'h0);
        check("rst_led", 32'(led_f), 32'h0);

        // Clean step: sw_db at edge 6, led_f at 7, f_chg pulse at 8 only
        @(negedge sys_clk);
        sys_rst = 1'b0; sw = 4'hF;
        for (int k = 1; k <= 10; k++) begin
            step();
            check("t1_db", 32'(sw_db), (k >= 6) ? 32'hF : 32'h0);
            check("t1_led", 32'(led_f), (k >= 7) ? 32'h1 : 32'h0);
            check("t1_chg", 32'(f_chg), (k == 8) ? 32'h1 : 32'h0);
        end

        // 3-cycle glitch on sw[0] is rejected
        sw = 4'hE;
        repeat (3) step();
        sw = 4'hF;
        repeat (8) begin
            step();
            check("t2_db", 32'(sw_db), 32'hF);
            check("t2_chg", 32'(f_chg), 32'h0);
        end

        // Mode sweep with sw_db = 0111
        sw = 4'h7;
        repeat (10) step();
        check("t3_db", 32'(sw_db), 32'h7);
        exp_tab = 8'b1100_1110;
        for (int m = 0; m < 8; m++) begin
            mode = 3'(m);
            step();
            check("t3_mode", 32'(led_f), 32'(exp_tab[m]));
            step();
        end

        // NAND after reset: led_f rises on first edge, f_chg on the second
        mode = 3'd3; sw = 4'h0; sys_rst = 1'b1;
        repeat (3) begin
            step();
            check("t4_rst_led", 32'(led_f), 32'h0);
        end
        sys_rst = 1'b0;
        step();
        check("t4_led", 32'(led_f), 32'h1);
        check("t4_chg0", 32'(f_chg), 32'h0);
        step();
        check("t4_chg1", 32'(f_chg), 32'h1);

        // Reset mid-debounce discards progress
        mode = 3'd0; sys_rst = 1'b1;
        step();
        sys_rst = 1'b0; sw = 4'hF;
        repeat (3) step();
        sys_rst = 1'b1;
        step();
        check("t5_db_rst", 32'(sw_db), 32'h0);
        sys_rst = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("t5_db", 32'(sw_db), (k >= 6) ? 32'hF : 32'h0);
        end

        // 256 settled toggles of sw[0] in PASS mode
        mode = 3'd7;
        sw = 4'h0;
        repeat (10) step();
        rc0 = m_rc;
        for (int j = 0; j < 256; j++) begin
            sw = 4'h1;
            repeat (9) step();
            sw = 4'h0;
            repeat (9) step();
        end
`ifdef F_EDGE_CNT_EN
        check("t6_wrap", 32'(rise_cnt), 32'(rc0));
`else
        check("t6_zero", 32'(rise_cnt), 32'h0);
`endif

        // Random traffic with glitches, mode changes and occasional resets
        hold = 0;
        for (int c = 0; c < 2000; c++) begin
            if (hold == 0) begin
                sw   = 4'($urandom);
                hold = int'($urandom_range(1, 8));
            end
            hold--;
            if ($urandom_range(0, 15) == 0) mode = 3'($urandom);
            sys_rst = ($urandom_range(0, 63) == 0);
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
